reg_file_sweep: RTL and testbench
=================================

// Module: reg_file_sweep
// PURPOSE
//   Parametrised register file: 2^ADDR_W registers of DATA_W bits, one write
//   port and two registered read ports. Adds a sequential clear-sweep engine
//   that zeroes all registers one per cycle, and optional write-to-read bypass.
//   Sits in the datapath as the architectural register store and is the
//   successor to the fixed 16x16 register file. Register 0 is exported
//   continuously for debug display.
// PARAMETERS
//   DATA_W   16   register width in bits
//   ADDR_W    4   address width; DEPTH = 2**ADDR_W registers
// PORTS
//   Clk      in   1        system clock; all state updates on rising edge
//   Reset    in   1        synchronous, active-high reset
//   W_data   in   DATA_W   write data
//   W_addr   in   ADDR_W   write address
//   W_en     in   1        write enable
//   R_addr0  in   ADDR_W   read address, port 0
//   R_en0    in   1        read enable, port 0
//   R_addr1  in   ADDR_W   read address, port 1
//   R_en1    in   1        read enable, port 1
//   Clr      in   1        start clear sweep (single-cycle pulse)
//   R_data0  out  DATA_W   registered read data, port 0
//   R_data1  out  DATA_W   registered read data, port 1
//   Busy     out  1        high while the clear sweep runs
//   RQ0      out  DATA_W   current contents of register 0, combinational from storage
// BEHAVIOUR
//   - Reset (Clk edge with Reset=1): all registers, R_data0/1, sweep counter
//     := 0; FSM := IDLE; Busy = 0; RQ0 = 0. Reset overrides every other input.
//   - Write: W_en=1 in IDLE stores W_data at W_addr on the edge. Register 0 is
//     writable.
//   - Read: 1-cycle latency. R_enN=1 at edge k, so R_dataN after edge k equals
//     reg[R_addrN] as sampled at edge k. R_enN=0 at edge k sets R_dataN to 0.
//     Both ports may address the same register.
//   - FSM IDLE -> SWEEP when Clr=1 in IDLE. A W_en in that same cycle is still
//     performed. Counter is set to 0 and Busy rises after the edge.
//   - SWEEP: each cycle writes 0 to reg[cnt], then cnt++. When cnt = DEPTH-1,
//     that register is cleared and FSM -> IDLE. Sweep lasts exactly DEPTH
//     cycles with Busy=1.
//   - In SWEEP: W_en ignored and the write is dropped silently. Clr ignored,
//     with no restart. Reads remain legal and return stored values.
//   - Reset mid-sweep: immediate full clear, FSM -> IDLE, Busy=0.
//   - Effective write each cycle is the W port (IDLE) or the sweep write
//     (SWEEP). At most one write per cycle.
//   - Counter is ADDR_W bits. Terminal detection is explicit, with no reliance
//     on wrap.
// CONFIGURATION
//   RF_BYPASS_EN defined: if the effective write address equals R_addrN in the
//     same cycle with R_enN=1, R_dataN captures the value being written
//     (W_data, or 0 during sweep).
//   RF_BYPASS_EN undefined: R_dataN captures the pre-write (old) register
//     value. The new value is visible on a read issued the following cycle.
// TESTING
//   1 Reset, then read all 16 regs on both ports -> every R_data = 0, Busy=0, RQ0=0.
//   2 Write 0xA5A5 to r3, 0x1234 to r0; read r3 on port 0 and r0 on port 1
//     -> next cycle 0xA5A5 / 0x1234; RQ0 = 0x1234.
//   3 Write r5 = 0xBEEF while reading r5 on port 1 in the same cycle
//     -> 0xBEEF with RF_BYPASS_EN, otherwise the old value; next-cycle read
//     = 0xBEEF in both builds.
//   4 Fill r0..r15 with 0x1000+i, pulse Clr -> Busy high for exactly 16 cycles.
//     W_en to r2 during the sweep is dropped. Afterwards all regs read 0.
//   5 Clr, then Reset asserted at sweep cycle 7 -> all regs 0, Busy=0 next cycle.
//     A second Clr during a sweep does not extend Busy.
//   6 R_en0=0 with a valid R_addr0 -> R_data0 = 0 next cycle. Port 1 is
//     unaffected.

Source files
------------

// File: rtl/reg_file_sweep.sv
// Register file, 2^ADDR_W x DATA_W, one write port, two registered read ports.
// Sequential clear sweep; optional same-cycle write-to-read bypass (RF_BYPASS_EN).
module reg_file_sweep #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] W_data,
  input  logic [ADDR_W-1:0] W_addr,
  input  logic              W_en,
  input  logic [ADDR_W-1:0] R_addr0,
  input  logic              R_en0,
  input  logic [ADDR_W-1:0] R_addr1,
  input  logic              R_en1,
  input  logic              Clr,
  output logic [DATA_W-1:0] R_data0,
  output logic [DATA_W-1:0] R_data1,
  output logic              Busy,
  output logic [DATA_W-1:0] RQ0
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rv0;
  logic [DATA_W-1:0] rv1;

  // Pick the single effective write: sweep clear or the external port.
  always_comb begin
    we = 1'b0;
    wa = W_addr;
    wd = W_data;
    if (state == SWEEP) begin
      we = 1'b1;
      wa = cnt;
      wd = '0;
    end else if (W_en) begin
      we = 1'b1;
    end
  end

  // Read values presented to the output registers, with optional bypass.
  always_comb begin
    rv0 = regs[R_addr0];
    rv1 = regs[R_addr1];
`ifdef RF_BYPASS_EN
    if (we && (wa == R_addr0)) rv0 = wd;
    if (we && (wa == R_addr1)) rv1 = wd;
`endif
  end

  // Storage, read registers and sweep FSM.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      R_data0 <= '0;
      R_data1 <= '0;
      cnt     <= '0;
      state   <= IDLE;
      Busy    <= 1'b0;
    end else begin
      if (we) regs[wa] <= wd;
      R_data0 <= R_en0 ? rv0 : '0;
      R_data1 <= R_en1 ? rv1 : '0;
      unique case (state)
        IDLE: begin
          if (Clr) begin
            state <= SWEEP;
            cnt   <= '0;
            Busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  assign RQ0 = regs[0];

endmodule

// File: tb/tb_reg_file_sweep.sv
// Bench for reg_file_sweep: directed vectors, literal checks and a
// per-cycle comparison against a behavioural model.
module tb_reg_file_sweep;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          Clk = 0;
  logic          Reset;
  logic [DW-1:0] W_data;
  logic [AW-1:0] W_addr;
  logic          W_en;
  logic [AW-1:0] R_addr0;
  logic          R_en0;
  logic [AW-1:0] R_addr1;
  logic          R_en1;
  logic          Clr;
  logic [DW-1:0] R_data0;
  logic [DW-1:0] R_data1;
  logic          Busy;
  logic [DW-1:0] RQ0;

  reg_file_sweep #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .Clk(Clk), .Reset(Reset),
    .W_data(W_data), .W_addr(W_addr), .W_en(W_en),
    .R_addr0(R_addr0), .R_en0(R_en0),
    .R_addr1(R_addr1), .R_en1(R_en1),
    .Clr(Clr),
    .R_data0(R_data0), .R_data1(R_data1),
    .Busy(Busy), .RQ0(RQ0)
  );

  always #5 Clk = ~Clk;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: memory array plus number of sweep cycles remaining.
  logic [DW-1:0] m [DEPTH];
  logic [DW-1:0] m_rd0, m_rd1;
  int            left;

  always @(posedge Clk) begin
    logic          we;
    int            wa;
    logic [DW-1:0] wd;
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
      m_rd0 = '0;
      m_rd1 = '0;
      left  = 0;
    end else begin
      we = 0; wa = 0; wd = '0;
      if (left > 0) begin
        we = 1; wa = DEPTH - left; wd = '0;
      end else if (W_en) begin
        we = 1; wa = int'(W_addr); wd = W_data;
      end
      m_rd0 = '0;
      m_rd1 = '0;
      if (R_en0) m_rd0 = (BYP && we && wa == int'(R_addr0)) ? wd : m[R_addr0];
      if (R_en1) m_rd1 = (BYP && we && wa == int'(R_addr1)) ? wd : m[R_addr1];
      if (we) m[wa] = wd;
      if (left > 0) left = left - 1;
      else if (Clr) left = DEPTH;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    if (chk_on) begin
      chk("model_rd0", 32'(R_data0), 32'(m_rd0));
      chk("model_rd1", 32'(R_data1), 32'(m_rd1));
      chk("model_busy", 32'(Busy), 32'(left > 0));
      chk("model_rq0", 32'(RQ0), 32'(m[0]));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic idle();
    W_en = 0; W_data = '0; W_addr = '0;
    R_en0 = 0; R_addr0 = '0; R_en1 = 0; R_addr1 = '0;
    Clr = 0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    idle();
    W_en = 1; W_addr = AW'(a); W_data = d;
    tick();
    idle();
  endtask

  task automatic read_all_zero(input string nm);
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      R_en0 = 1; R_addr0 = AW'(i);
      R_en1 = 1; R_addr1 = AW'(DEPTH - 1 - i);
      tick();
      chk({nm, "_p0"}, 32'(R_data0), 32'h0);
      chk({nm, "_p1"}, 32'(R_data1), 32'h0);
    end
    idle();
  endtask

  task automatic count_busy(input int clr_at, input int wr_at, output int n);
    n = 0;
    while (Busy && n < 40) begin
      idle();
      if (n == clr_at) Clr = 1;
      if (n == wr_at) begin
        W_en = 1; W_addr = 4'd2; W_data = 16'h7777;
      end
      n++;
      tick();
    end
    idle();
  endtask

  int n;

  initial begin
    idle();
    Reset = 1;
    tick();
    tick();
    Reset = 0;
    chk_on = 1;

    // 1: reset state
    chk("reset_busy", 32'(Busy), 32'h0);
    chk("reset_rq0", 32'(RQ0), 32'h0);
    read_all_zero("reset_read");

    // 2: basic write/read
    wr(3, 16'hA5A5);
    wr(0, 16'h1234);
    R_en0 = 1; R_addr0 = 4'd3; R_en1 = 1; R_addr1 = 4'd0;
    tick();
    idle();
    chk("rd_r3", 32'(R_data0), 32'hA5A5);
    chk("rd_r0", 32'(R_data1), 32'h1234);
    chk("rq0", 32'(RQ0), 32'h1234);

    // 3: write/read collision on r5
    W_en = 1; W_addr = 4'd5; W_data = 16'hBEEF;
    R_en1 = 1; R_addr1 = 4'd5;
    tick();
    idle();
    chk("collide_r5", 32'(R_data1), BYP ? 32'hBEEF : 32'h0);
    R_en1 = 1; R_addr1 = 4'd5;
    tick();
    idle();
    chk("after_r5", 32'(R_data1), 32'hBEEF);

    // 6: port 0 disabled, port 1 unaffected
    wr(3, 16'h55AA);
    R_en0 = 0; R_addr0 = 4'd3; R_en1 = 1; R_addr1 = 4'd3;
    tick();
    idle();
    chk("ren0_off", 32'(R_data0), 32'h0);
    chk("ren1_on", 32'(R_data1), 32'h55AA);

    // 4: fill, sweep with dropped write
    for (int i = 0; i < DEPTH; i++) wr(i, 16'(16'h1000 + i));
    chk("fill_rq0", 32'(RQ0), 32'h1000);
    Clr = 1;
    tick();
    idle();
    chk("sweep_busy_rise", 32'(Busy), 32'h1);
    count_busy(-1, 5, n);
    chk("sweep_len", n, 16);
    chk("sweep_done_busy", 32'(Busy), 32'h0);
    read_all_zero("post_sweep");

    // 5a: second Clr during sweep
    wr(9, 16'h0909);
    Clr = 1;
    tick();
    idle();
    count_busy(4, -1, n);
    chk("reclr_len", n, 16);

    // 5b: reset at sweep cycle 7
    wr(15, 16'hF00F);
    wr(0, 16'h0101);
    Clr = 1;
    tick();
    idle();
    for (int i = 0; i < 6; i++) tick();
    chk("mid_busy", 32'(Busy), 32'h1);
    Reset = 1;
    tick();
    Reset = 0;
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_rq0", 32'(RQ0), 32'h0);
    read_all_zero("post_rst");
    tick();

    chk_on = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
